// File: rtl/fetch_pkg.sv
// Shared fetch-stage types: sequencer states and prefetch queue sizing.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  localparam int QUEUE_DEPTH = 2;
  localparam int OCC_W       = $clog2(QUEUE_DEPTH + 1);
  localparam logic [OCC_W-1:0] QUEUE_FULL = OCC_W'(QUEUE_DEPTH);

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: program memory port, redirect/halt controls and decoder handshake.
interface fetch_unit_if #(
  parameter int WIDTH         = 16,
  parameter int COUNTER_WIDTH = 8
);

  logic [COUNTER_WIDTH-1:0] count;
  logic [WIDTH-1:0]         mem_instruction;
  logic                     jump_valid;
  logic [COUNTER_WIDTH-1:0] jump_target;
  logic                     halt;
  logic                     instr_valid;
  logic                     instr_ready;
  logic [WIDTH-1:0]         instruction;
  logic [COUNTER_WIDTH-1:0] instr_pc;
  logic                     halted;

  modport master (
    output count, instr_valid, instruction, instr_pc, halted,
    input  mem_instruction, jump_valid, jump_target, halt, instr_ready
  );

  modport slave (
    input  count, instr_valid, instruction, instr_pc, halted,
    output mem_instruction, jump_valid, jump_target, halt, instr_ready
  );

endinterface

// File: rtl/fetch_queue.sv
// Two-entry {word, pc} prefetch FIFO; head is registered (no bypass), flush dominates.
// Head slot is only overwritten by new data, so an empty queue keeps showing the last word.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int WIDTH         = 16,
  parameter int COUNTER_WIDTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         push_word,
  input  logic [COUNTER_WIDTH-1:0] push_pc,
  output logic [WIDTH-1:0]         head_word,
  output logic [COUNTER_WIDTH-1:0] head_pc,
  output logic [OCC_W-1:0]         occupancy
);

  typedef struct packed {
    logic [WIDTH-1:0]         word;
    logic [COUNTER_WIDTH-1:0] pc;
  } entry_t;

  entry_t head;
  entry_t tail;
  entry_t din;
  logic   pop_eff;
  logic   push_eff;

  assign din      = {push_word, push_pc};
  assign pop_eff  = pop && (occupancy != '0);
  assign push_eff = push && ((occupancy != QUEUE_FULL) || pop_eff);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head      <= '0;
      tail      <= '0;
      occupancy <= '0;
    end else if (flush) begin
      occupancy <= '0;
    end else if (pop_eff && !push_eff) begin
      if (occupancy == QUEUE_FULL) head <= tail;
      occupancy <= occupancy - OCC_W'(1);
    end else if (push_eff && !pop_eff) begin
      if (occupancy == '0) head <= din;
      else                 tail <= din;
      occupancy <= occupancy + OCC_W'(1);
    end else if (push_eff && pop_eff) begin
      if (occupancy == QUEUE_FULL) begin
        head <= tail;
        tail <= din;
      end else begin
        head <= din;
      end
    end
  end

  assign head_word = head.word;
  assign head_pc   = head.pc;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC sequencer feeding a 2-deep prefetch queue to the decoder.
// Head visible one edge after fetch; count stalls while the queue is full and not popping.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int WIDTH         = 16,
  parameter int COUNTER_WIDTH = 8
) (
  input  logic         clock,
  input  logic         reset,
  fetch_unit_if.master bus
);

  fetch_state_t             state;
  logic [COUNTER_WIDTH-1:0] count_q;
  logic [OCC_W-1:0]         occupancy;
  logic [WIDTH-1:0]         head_word;
  logic [COUNTER_WIDTH-1:0] head_pc;
  logic                     instr_valid;
  logic                     pop;
  logic                     push;
  logic                     flush;

  assign instr_valid = (occupancy != '0);
  assign pop         = instr_valid && bus.instr_ready;
  // A redirect is ignored in IDLE; elsewhere it wins over push, pop and halt.
  assign flush       = bus.jump_valid && (state != IDLE);
  assign push        = (state == RUN) && !bus.jump_valid && !bus.halt &&
                       ((occupancy != QUEUE_FULL) || pop);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      count_q <= '0;
    end else begin
      case (state)
        IDLE: state <= RUN;
        RUN: begin
          if (flush) begin
            count_q <= bus.jump_target;
          end else begin
            if (push)     count_q <= count_q + COUNTER_WIDTH'(1);
            if (bus.halt) state   <= HALTED;
          end
        end
        HALTED: begin
          if (flush) begin
            count_q <= bus.jump_target;
            state   <= RUN;
          end else if (!bus.halt) begin
            state <= RUN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  fetch_queue #(
    .WIDTH         (WIDTH),
    .COUNTER_WIDTH (COUNTER_WIDTH)
  ) u_queue (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .pop       (pop && !flush),
    .flush     (flush),
    .push_word (bus.mem_instruction),
    .push_pc   (count_q),
    .head_word (head_word),
    .head_pc   (head_pc),
    .occupancy (occupancy)
  );

  assign bus.count       = count_q;
  assign bus.instr_valid = instr_valid;
  assign bus.instruction = head_word;
  assign bus.instr_pc    = head_pc;
  assign bus.halted      = (state == HALTED) && (occupancy == '0);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random traffic against a queue model.
module tb_fetch_unit;

  logic clock = 1'b0;
  logic reset = 1'b1;
  bit   check_en = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  fetch_unit_if #(.WIDTH(16), .COUNTER_WIDTH(8)) bus ();

  fetch_unit #(.WIDTH(16), .COUNTER_WIDTH(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [15:0] memf(input logic [7:0] a);
    return {~a, a};
  endfunction

  assign bus.mem_instruction = memf(bus.count);

  typedef struct {
    logic [15:0] word;
    logic [7:0]  pc;
  } ent_t;

  ent_t        m_q[$];
  int          m_mode;   // 0 idle, 1 run, 2 halted
  logic [7:0]  m_count;
  logic [15:0] m_word;
  logic [7:0]  m_pc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_mode  = 0;
    m_count = 8'd0;
    m_word  = 16'd0;
    m_pc    = 8'd0;
  endtask

  task automatic model_edge();
    bit   pop;
    bit   push;
    ent_t e;
    if (!reset) begin
      model_reset();
      return;
    end
    pop = (m_q.size() > 0) && bus.instr_ready;
    if (m_mode == 0) begin
      m_mode = 1;
    end else if (bus.jump_valid) begin
      m_q.delete();
      m_count = bus.jump_target;
      m_mode  = 1;
    end else if (m_mode == 1) begin
      push = !bus.halt && ((m_q.size() < 2) || pop);
      if (pop) e = m_q.pop_front();
      if (push) begin
        e.word = memf(m_count);
        e.pc   = m_count;
        m_q.push_back(e);
        m_count = m_count + 8'd1;
      end
      if (bus.halt) m_mode = 2;
    end else begin
      if (pop) e = m_q.pop_front();
      if (!bus.halt) m_mode = 1;
    end
    if (m_q.size() > 0) begin
      m_word = m_q[0].word;
      m_pc   = m_q[0].pc;
    end
  endtask

  always @(negedge clock) begin
    if (check_en) begin
      chk("count",       32'(bus.count),       32'(m_count));
      chk("instr_valid", 32'(bus.instr_valid), 32'(m_q.size() > 0));
      chk("instruction", 32'(bus.instruction), 32'(m_word));
      chk("instr_pc",    32'(bus.instr_pc),    32'(m_pc));
      chk("halted",      32'(bus.halted),      32'((m_mode == 2) && (m_q.size() == 0)));
    end
  end

  task automatic step();
    @(posedge clock);
    model_edge();
    #2;
  endtask

  task automatic do_reset(input logic ready);
    reset = 1'b0;
    model_reset();
    bus.instr_ready = ready;
    bus.jump_valid  = 1'b0;
    bus.halt        = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  initial begin
    bus.jump_valid  = 1'b0;
    bus.jump_target = 8'd0;
    bus.halt        = 1'b0;
    bus.instr_ready = 1'b0;
    #1;
    reset = 1'b0;
    model_reset();
    check_en = 1'b1;

    // Reset release, ready high: pc sequence 0,1,2,3
    do_reset(1'b1);
    step();
    chk("s1_valid_edge1", 32'(bus.instr_valid), 32'd0);
    step();
    chk("s1_valid_edge2", 32'(bus.instr_valid), 32'd1);
    chk("s1_word0", 32'(bus.instruction), 32'h0000_FF00);
    chk("s1_pc0", 32'(bus.instr_pc), 32'd0);
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("s1_pc_seq", 32'(bus.instr_pc), 32'(i));
    end
    chk("s1_count", 32'(bus.count), 32'd4);

    // Ready low from reset: fill to 2, count stalls at 2
    do_reset(1'b0);
    repeat (5) step();
    chk("s2_count_stall", 32'(bus.count), 32'd2);
    chk("s2_valid", 32'(bus.instr_valid), 32'd1);
    chk("s2_word_hold", 32'(bus.instruction), 32'h0000_FF00);
    bus.instr_ready = 1'b1;
    for (int i = 0; i <= 2; i++) begin
      chk("s2_drain_valid", 32'(bus.instr_valid), 32'd1);
      chk("s2_drain_pc", 32'(bus.instr_pc), 32'(i));
      step();
    end

    // Jump to 0x40 with full queue
    bus.instr_ready = 1'b0;
    repeat (2) step();
    bus.jump_valid  = 1'b1;
    bus.jump_target = 8'h40;
    step();
    chk("s3_bubble", 32'(bus.instr_valid), 32'd0);
    chk("s3_count", 32'(bus.count), 32'h40);
    bus.jump_valid  = 1'b0;
    bus.instr_ready = 1'b1;
    step();
    chk("s3_pc40", 32'(bus.instr_pc), 32'h40);
    chk("s3_word40", 32'(bus.instruction), 32'h0000_BF40);
    step();
    chk("s3_pc41", 32'(bus.instr_pc), 32'h41);

    // Address wrap 0xFE, 0xFF, 0x00
    bus.jump_valid  = 1'b1;
    bus.jump_target = 8'hFE;
    step();
    chk("s4_bubble", 32'(bus.instr_valid), 32'd0);
    bus.jump_valid = 1'b0;
    step();
    chk("s4_pcFE", 32'(bus.instr_pc), 32'hFE);
    step();
    chk("s4_pcFF", 32'(bus.instr_pc), 32'hFF);
    step();
    chk("s4_pc00", 32'(bus.instr_pc), 32'h00);
    chk("s4_count", 32'(bus.count), 32'd1);

    // Halt at count 5, drain, resume from 5
    bus.jump_valid  = 1'b1;
    bus.jump_target = 8'd3;
    step();
    bus.jump_valid = 1'b0;
    step();
    step();
    chk("s5_count5", 32'(bus.count), 32'd5);
    bus.halt = 1'b1;
    step();
    chk("s5_halted", 32'(bus.halted), 32'd1);
    chk("s5_valid", 32'(bus.instr_valid), 32'd0);
    step();
    chk("s5_count_hold", 32'(bus.count), 32'd5);
    bus.halt = 1'b0;
    step();
    chk("s5_unhalted", 32'(bus.halted), 32'd0);
    step();
    chk("s5_resume_pc", 32'(bus.instr_pc), 32'd5);
    chk("s5_resume_valid", 32'(bus.instr_valid), 32'd1);

    // Asynchronous reset mid-stream with full queue
    bus.instr_ready = 1'b0;
    repeat (3) step();
    chk("s6_full_valid", 32'(bus.instr_valid), 32'd1);
    reset = 1'b0;
    model_reset();
    #1;
    chk("s6_rst_count", 32'(bus.count), 32'd0);
    chk("s6_rst_valid", 32'(bus.instr_valid), 32'd0);
    chk("s6_rst_word", 32'(bus.instruction), 32'd0);
    chk("s6_rst_pc", 32'(bus.instr_pc), 32'd0);
    chk("s6_rst_halted", 32'(bus.halted), 32'd0);
    step();
    bus.instr_ready = 1'b1;
    reset = 1'b1;
    step();
    chk("s6_edge1_valid", 32'(bus.instr_valid), 32'd0);
    step();
    chk("s6_edge2_pc", 32'(bus.instr_pc), 32'd0);
    step();
    chk("s6_edge3_pc", 32'(bus.instr_pc), 32'd1);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      bus.instr_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 15) == 0) bus.halt = !bus.halt;
      bus.jump_valid = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 3) == 0) bus.jump_target = 8'(8'hFC + $urandom_range(0, 3));
      else                           bus.jump_target = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 499) == 0) begin
        reset = 1'b0;
        model_reset();
      end else begin
        reset = 1'b1;
      end
      step();
    end

    check_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
